// File: rtl/p66btxsched.sv
// 10GBASE-R TX block scheduler: guarantees a legal 66-bit block on every gearbox pull.
// Optional fault ordered-set insertion is built when P66BTXSCHED_FAULT_EN is defined.
module p66btxsched (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [65:0] S_DATA,
  input  logic        M_READY,
  output logic [65:0] M_DATA,
  input  logic        i_send_lf,
  input  logic        i_send_rf,
  output logic [15:0] o_underruns
);

  localparam int unsigned BLK_W = 66;
  localparam int unsigned CNT_W = 16;

  localparam logic [BLK_W-1:0] BLK_IDLE = {56'h0, 8'h1E, 2'b10};
  localparam logic [BLK_W-1:0] BLK_ERR  = {{8{7'h1E}}, 8'h1E, 2'b10};

  typedef enum logic [1:0] {
    ST_GAP,
    ST_PKT,
    ST_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   blk_d;
  logic               cnt_inc;
  logic               fault_pend;
  logic [BLK_W-1:0]   fault_blk;
  logic [1:0]         sync;
  logic [7:0]         btype;
  logic               is_ctrl, is_data, is_start, is_term;

  assign sync     = S_DATA[1:0];
  assign btype    = S_DATA[9:2];
  assign is_ctrl  = (sync == 2'b10);
  assign is_data  = (sync == 2'b01);
  assign is_start = is_ctrl && ((btype == 8'h78) || (btype == 8'h33));
  assign is_term  = is_ctrl && (btype inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                              8'hCC, 8'hD2, 8'hE1, 8'hFF});

`ifdef P66BTXSCHED_FAULT_EN
  localparam logic [BLK_W-1:0] BLK_LF = {32'h0, 8'h01, 16'h0, 8'h4B, 2'b10};
  localparam logic [BLK_W-1:0] BLK_RF = {32'h0, 8'h02, 16'h0, 8'h4B, 2'b10};

  assign fault_pend = i_send_lf | i_send_rf;
  assign fault_blk  = i_send_lf ? BLK_LF : BLK_RF;
`else
  logic unused_fault;
  assign unused_fault = i_send_lf ^ i_send_rf;
  assign fault_pend   = 1'b0;
  assign fault_blk    = BLK_IDLE;
`endif

  // Encoder is held off only while an ordered set is being inserted between frames.
  assign S_READY = M_READY && !((state_q == ST_GAP) && fault_pend);

  // Next-state and block selection for one gearbox pull
  always_comb begin
    state_d = state_q;
    blk_d   = BLK_IDLE;
    cnt_inc = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (fault_pend) begin
          blk_d = fault_blk;
        end else if (S_VALID) begin
          if (is_start) begin
            blk_d   = S_DATA;
            state_d = ST_PKT;
          end else if (is_ctrl) begin
            blk_d = S_DATA;
          end else begin
            // Data outside a frame is never legal; invalid sync headers are errored but not counted.
            blk_d   = BLK_ERR;
            cnt_inc = is_data;
          end
        end
      end
      ST_PKT: begin
        if (S_VALID) begin
          blk_d = S_DATA;
          if (is_term) state_d = ST_GAP;
        end else begin
          blk_d   = BLK_ERR;
          cnt_inc = 1'b1;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (S_VALID && is_term) state_d = ST_GAP;
      end
      default: state_d = ST_GAP;
    endcase
  end

  // All state advances only on pull cycles
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_GAP;
      M_DATA      <= BLK_IDLE;
      o_underruns <= '0;
    end else if (M_READY) begin
      state_q <= state_d;
      M_DATA  <= blk_d;
      if (cnt_inc && (o_underruns != {CNT_W{1'b1}}))
        o_underruns <= o_underruns + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_p66btxsched.sv
// Self-checking bench for p66btxsched: frame-level reference model plus directed literal checks.
module tb_p66btxsched;

`ifdef P66BTXSCHED_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  localparam logic [65:0] B_IDLE = {56'h0, 8'h1E, 2'b10};
  localparam logic [65:0] B_ERR  = {{8{7'h1E}}, 8'h1E, 2'b10};
  localparam logic [65:0] B_LF   = {32'h0, 8'h01, 16'h0, 8'h4B, 2'b10};
  localparam logic [65:0] B_RF   = {32'h0, 8'h02, 16'h0, 8'h4B, 2'b10};
  localparam logic [65:0] B_ST   = {56'h11223344556677, 8'h78, 2'b10};
  localparam logic [65:0] B_ST2  = {56'hA1A2A3A4A5A6A7, 8'h33, 2'b10};
  localparam logic [65:0] B_D1   = {64'h0123456789ABCDEF, 2'b01};
  localparam logic [65:0] B_D2   = {64'hFEDCBA9876543210, 2'b01};
  localparam logic [65:0] B_D3   = {64'h5555AAAA3333CCCC, 2'b01};
  localparam logic [65:0] B_TRM  = {56'h0, 8'h87, 2'b10};
  localparam logic [65:0] B_TRM2 = {56'h00000000000042, 8'hFF, 2'b10};

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        S_VALID, S_READY, M_READY;
  logic [65:0] S_DATA, M_DATA;
  logic        i_send_lf, i_send_rf;
  logic [15:0] o_underruns;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_pkt, m_drop;
  int          m_cnt;
  logic [65:0] m_exp;
  logic [65:0] pulled[$];
  bit          last_rdy;

  always #5 i_clk = ~i_clk;

  p66btxsched dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_READY(M_READY), .M_DATA(M_DATA),
    .i_send_lf(i_send_lf), .i_send_rf(i_send_rf),
    .o_underruns(o_underruns)
  );

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_start(input logic [65:0] d);
    return d[1:0] == 2'b10 && (d[9:2] == 8'h78 || d[9:2] == 8'h33);
  endfunction

  function automatic bit is_term(input logic [65:0] d);
    return d[1:0] == 2'b10 && (d[9:2] inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                               8'hCC, 8'hD2, 8'hE1, 8'hFF});
  endfunction

  // Per-cycle compare against the frame-level model
  initial begin : monitor
    bit s_rst, s_v, s_mr, s_lf, s_rf, fault, acc;
    logic [65:0] s_d;
    m_pkt = 0; m_drop = 0; m_cnt = 0; m_exp = B_IDLE;
    forever begin
      @(negedge i_clk); #4;
      s_rst = i_reset_n; s_v = S_VALID; s_d = S_DATA; s_mr = M_READY;
      s_lf = i_send_lf; s_rf = i_send_rf;
      if (!s_rst) begin
        m_pkt = 0; m_drop = 0; m_cnt = 0; m_exp = B_IDLE;
      end
      fault = FEN && (s_lf || s_rf) && !m_pkt && !m_drop;
      chk("s_ready", 66'(S_READY), 66'(s_mr && !fault));
      @(posedge i_clk); #1;
      if (s_rst && s_mr) begin
        acc = s_v && !fault;
        if (fault) m_exp = s_lf ? B_LF : B_RF;
        else if (m_drop) begin
          m_exp = B_IDLE;
          if (acc && is_term(s_d)) m_drop = 0;
        end else if (m_pkt) begin
          if (acc) begin
            m_exp = s_d;
            if (is_term(s_d)) m_pkt = 0;
          end else begin
            m_exp = B_ERR; m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_pkt = 0; m_drop = 1;
          end
        end else if (acc) begin
          if (is_start(s_d)) begin m_exp = s_d; m_pkt = 1; end
          else if (s_d[1:0] == 2'b10) m_exp = s_d;
          else begin
            m_exp = B_ERR;
            if (s_d[1:0] == 2'b01) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
          end
        end else m_exp = B_IDLE;
        pulled.push_back(M_DATA);
      end
      chk("m_data", M_DATA, m_exp);
      chk("underruns", 66'(o_underruns), 66'(m_cnt));
    end
  end

  task automatic drive(input bit v, input logic [65:0] d, input bit mr, input bit lf,
                       input bit rf, output bit acc);
    @(negedge i_clk);
    S_VALID = v; S_DATA = d; M_READY = mr; i_send_lf = lf; i_send_rf = rf;
    #4;
    last_rdy = S_READY;
    acc = v && S_READY;
    @(posedge i_clk); #2;
  endtask

  task automatic send(input logic [65:0] d, input bit stall, input bit lf, input bit rf);
    bit acc;
    int n;
    n = 0;
    acc = 0;
    if (stall) drive(1'b1, d, 1'b0, lf, rf, acc);
    while (!acc && n < 20) begin
      drive(1'b1, d, 1'b1, lf, rf, acc);
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_consumed expected=consumed block=%h", d);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b0, acc);
  endtask

  initial begin : stim
    bit acc;
    int base;
    logic [65:0] exp_q[$];
    S_VALID = 0; S_DATA = '0; M_READY = 0; i_send_lf = 0; i_send_rf = 0;
    i_reset_n = 1'b1;
    #1 i_reset_n = 1'b0;

    // Reset state with the gearbox idle
    for (int i = 0; i < 3; i++) drive(1'b0, B_IDLE, 1'b0, 1'b0, 1'b0, acc);
    chk("rst_s_ready", 66'(last_rdy), 66'(0));
    chk("rst_m_data", M_DATA, B_IDLE);
    chk("rst_underruns", 66'(o_underruns), 66'(0));
    i_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b0, acc);
      chk("idle_m_data", M_DATA, B_IDLE);
      chk("idle_s_ready", 66'(last_rdy), 66'(1));
    end

    // Clean packet with one gearbox stall
    base = pulled.size();
    send(B_ST, 0, 0, 0); send(B_D1, 0, 0, 0); send(B_D2, 1, 0, 0);
    send(B_D3, 0, 0, 0); send(B_TRM, 0, 0, 0);
    idle(2);
    exp_q = '{B_ST, B_D1, B_D2, B_D3, B_TRM, B_IDLE};
    foreach (exp_q[i]) chk($sformatf("pkt_blk%0d", i), pulled[base+i], exp_q[i]);

    // Mid-packet underrun drains to the terminate
    base = pulled.size();
    send(B_ST, 0, 0, 0); send(B_D1, 0, 0, 0);
    drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b0, acc);
    send(B_D2, 0, 0, 0); send(B_D3, 0, 0, 0); send(B_TRM, 0, 0, 0);
    send(B_ST2, 0, 0, 0); send(B_TRM2, 0, 0, 0);
    exp_q = '{B_ST, B_D1, B_ERR, B_IDLE, B_IDLE, B_IDLE, B_ST2, B_TRM2};
    foreach (exp_q[i]) chk($sformatf("urun_blk%0d", i), pulled[base+i], exp_q[i]);
    chk("urun_count", 66'(o_underruns), 66'(1));

    // Fault ordered sets in the gap
    drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b1, acc);
    drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b1, acc);
    chk("rf_block", M_DATA, FEN ? B_RF : B_IDLE);
    chk("rf_s_ready", 66'(last_rdy), 66'(!FEN));
    drive(1'b0, B_IDLE, 1'b1, 1'b1, 1'b1, acc);
    chk("lf_wins", M_DATA, FEN ? B_LF : B_IDLE);
    send(B_ST, 0, 0, 0);
    chk("fault_clear_pass", M_DATA, B_ST);
    send(B_TRM, 0, 0, 0);

    // Local fault raised mid-packet waits for the terminate
    base = pulled.size();
    send(B_ST, 0, 0, 0); send(B_D1, 0, 1, 0); send(B_TRM, 0, 1, 0);
    drive(1'b0, B_IDLE, 1'b1, 1'b1, 1'b0, acc);
    drive(1'b0, B_IDLE, 1'b1, 1'b1, 1'b0, acc);
    exp_q = '{B_ST, B_D1, B_TRM, FEN ? B_LF : B_IDLE, FEN ? B_LF : B_IDLE};
    foreach (exp_q[i]) chk($sformatf("lfmid_blk%0d", i), pulled[base+i], exp_q[i]);
    idle(1);

    // Reset mid-packet aborts without an ERR
    send(B_ST, 0, 0, 0); send(B_D1, 0, 0, 0);
    i_reset_n = 1'b0;
    drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b0, acc);
    chk("midrst_m_data", M_DATA, B_IDLE);
    chk("midrst_count", 66'(o_underruns), 66'(0));
    i_reset_n = 1'b1;
    drive(1'b0, B_IDLE, 1'b1, 1'b0, 1'b0, acc);
    chk("postrst_m_data", M_DATA, B_IDLE);

    // Stray data in the gap, then counter saturation
    send(B_D1, 0, 0, 0);
    chk("stray_err", M_DATA, B_ERR);
    chk("stray_count", 66'(o_underruns), 66'(1));
    for (int i = 0; i < 65540; i++) drive(1'b1, B_D2, 1'b1, 1'b0, 1'b0, acc);
    chk("sat_count", 66'(o_underruns), 66'(16'hFFFF));
    drive(1'b1, B_D3, 1'b0, 1'b0, 1'b0, acc);
    chk("freeze_count", 66'(o_underruns), 66'(16'hFFFF));
    drive(1'b1, B_D3, 1'b1, 1'b0, 1'b0, acc);
    chk("sat_hold", 66'(o_underruns), 66'(16'hFFFF));
    chk("sat_err", M_DATA, B_ERR);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p66btxsched.md
# p66btxsched

Transmit block scheduler for the 10GBASE-R path, sitting between the 64b/66b encoder and the 66-to-64 TX gearbox. The gearbox has no valid input and pulls a 66-bit block on every cycle its ready is high. This block guarantees a legal block on every such pull: it passes encoder blocks through, and otherwise substitutes idle, error or link-fault ordered-set blocks. It also turns mid-packet encoder underruns into a properly errored, fully drained frame.

## Interface

- No parameters.
- i_clk  in  1  sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- S_VALID  in  1  encoder block valid.
- S_READY  out  1  encoder block consumed this cycle when S_VALID && S_READY.
- S_DATA  in  66  encoder block: [1:0] sync, [9:2] block type, [65:10] payload.
- M_READY  in  1  gearbox pulling a block this cycle (gearbox S_READY).
- M_DATA  out  66  block presented to the gearbox; always valid.
- i_send_lf  in  1  request local-fault ordered sets.
- i_send_rf  in  1  request remote-fault ordered sets.
- o_underruns  out  16  saturating count of mid-packet underruns plus stray data blocks.

## Operation

- Block constants:
  - IDLE: sync 2'b10, type 8'h1E, payload 0.
  - ERR: sync 2'b10, type 8'h1E, payload = eight 7'h1E characters.
  - LF/RF ordered set: sync 2'b10, type 8'h4B, [33:26] = 8'h01 (LF) or 8'h02 (RF), all other payload bits 0.
- Start block: sync 2'b10 with type 8'h78 or 8'h33.
- Terminate block: sync 2'b10 with type in {87,99,AA,B4,CC,D2,E1,FF}.
- State machine, evaluated only on cycles with M_READY=1; the state holds otherwise:
  - GAP (reset state):
    - Fault pending → emit LF (LF wins over RF); S_READY=0.
    - Else S_VALID with a start block → pass it; go PKT.
    - Else S_VALID with any other control block → pass it.
    - Else S_VALID with a data block (sync 2'b01) → consume it, emit ERR, count it.
    - Else → emit IDLE.
  - PKT:
    - S_VALID → pass the block; a terminate block returns to GAP.
    - !S_VALID (underrun) → emit ERR, count it; go DROP.
    - Fault inputs are ignored in this state.
  - DROP:
    - S_READY=M_READY; every consumed block is discarded.
    - IDLE is emitted each pull.
    - Consuming a terminate block returns to GAP. A start block seen in DROP is also discarded.
- S_READY = M_READY && !(GAP && fault pending). It is combinational, with no dependence on S_VALID.
- o_underruns saturates at 16'hFFFF.

## Timing

- M_DATA is registered: it is loaded with the selected block on each cycle with M_READY=1 and held otherwise. Encoder-to-gearbox latency is one M_READY cycle.
- Reset values: M_DATA=IDLE, state=GAP, o_underruns=0, S_READY=0.
- Reset asserted mid-packet aborts immediately. No ERR is emitted, and the first post-reset pull returns IDLE.
- Fault inputs are sampled only in GAP, on M_READY cycles. Deasserting a fault lets the next GAP pull accept the encoder.
- A terminate block and a fault request in the same cycle: the terminate passes, and the next pull emits the ordered set.
- M_READY=0 freezes every register, including the counter.

## Configuration

- P66BTXSCHED_FAULT_EN:
  - Defined: fault ordered-set insertion is built as described.
  - Undefined: i_send_lf and i_send_rf are ignored, no ordered set is ever generated, and S_READY=M_READY in every state.

## Test plan

- Reset, S_VALID=0, M_READY=1 for 10 cycles → M_DATA=IDLE every cycle, S_READY=1, o_underruns=0.
- Packet start(78), 3 data blocks, terminate(87), with M_READY low 1 cycle in 33 → the same 5 blocks appear on M_DATA in order, one pull late, with no duplication or loss.
- Start then 1 data block, S_VALID low 1 cycle, then 2 data blocks and a terminate → ERR emitted at the gap, the 3 later blocks consumed but replaced by IDLE, o_underruns=1, next start passes normally.
- i_send_rf=1 in GAP → M_DATA = 4B ordered set with [33:26]=8'h02 and S_READY=0. Asserting i_send_lf as well switches it to 8'h01. Dropping both restores passthrough on the next pull.
- i_send_lf raised mid-packet → the packet completes through its terminate, then the LF ordered set begins.
- Data-sync block offered in GAP → ERR emitted, block consumed, o_underruns increments. With o_underruns preset to FFFF, the counter stays at FFFF.
